// File: rtl/mem_slave_pkg.sv
// Shared types and constants for simple_mem_slave: FSM state encoding and the
// write-protected address window used when MEM_WPROT_EN is defined.
package mem_slave_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StWrite,
    StRead,
    StResp
  } state_e;

  localparam logic [5:0] WPROT_BASE = 6'h38;
  localparam logic [5:0] WPROT_LAST = 6'h3F;

  // Zero-extend so the window check works for any address width.
  function automatic logic in_wprot(logic [31:0] a);
    return (a >= 32'(WPROT_BASE)) && (a <= 32'(WPROT_LAST));
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous active-low reset; holds at all-ones.
module sat_counter #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (inc && (count_q != '1)) begin
      count_q <= count_q + 1'b1;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/simple_mem_slave.sv
// Register-array memory slave with a 4-state access FSM and access counters.
// Optional MEM_WPROT_EN: writes to 0x38-0x3F are dropped and flagged on err.
module simple_mem_slave
  import mem_slave_pkg::*;
#(
  parameter int unsigned ADDR_W = 6,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              wr,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              ready,
  output logic [DATA_W-1:0] rdata,
  output logic              rvalid,
  output logic [CNT_W-1:0]  wr_cnt,
  output logic [CNT_W-1:0]  rd_cnt,
  output logic              err
);

  localparam int unsigned Depth = 2 ** ADDR_W;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W-1:0]   rdata_q;
  logic                rvalid_q;
  logic                err_q;
  logic                wprot_q;
  logic [DATA_W-1:0]   mem_q [Depth];
  logic                accept;
  logic                wprot_hit;
  logic                wr_inc;
  logic                rd_inc;

  assign ready  = (state_q == StIdle);
  assign accept = en && ready;

`ifdef MEM_WPROT_EN
  assign wprot_hit = in_wprot(32'(addr));
`else
  assign wprot_hit = 1'b0;
`endif

  assign wr_inc = accept && wr && !wprot_hit;
  assign rd_inc = accept && !wr;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (accept) state_d = wr ? StWrite : StRead;
      StWrite: state_d = StIdle;
      StRead:  state_d = StResp;
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
      wprot_q  <= 1'b0;
      for (int unsigned i = 0; i < Depth; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q  <= state_d;
      // rvalid is high exactly while the FSM sits in RESP.
      rvalid_q <= (state_q == StRead);
      err_q    <= accept && wr && wprot_hit;
      if (accept) begin
        addr_q  <= addr;
        wdata_q <= wdata;
        wprot_q <= wr && wprot_hit;
      end
      if (state_q == StWrite && !wprot_q) begin
        mem_q[addr_q] <= wdata_q;
      end
      if (state_q == StRead) begin
        rdata_q <= mem_q[addr_q];
      end
    end
  end

  assign rdata  = rdata_q;
  assign rvalid = rvalid_q;
  assign err    = err_q;

  sat_counter #(
    .WIDTH (CNT_W)
  ) u_wr_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (wr_inc),
    .count (wr_cnt)
  );

  sat_counter #(
    .WIDTH (CNT_W)
  ) u_rd_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (rd_inc),
    .count (rd_cnt)
  );

endmodule

// File: doc/simple_mem_slave.md
SIMPLE_MEM_SLAVE -- requirements
Module: simple_mem_slave

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 6, meaning address width (64 entries).
REQ-002 The block SHALL have parameter DATA_W, default 8, meaning data word width.
REQ-003 The block SHALL have parameter CNT_W, default 16, meaning access-counter width.
REQ-004 The block SHALL use one clock; reset is synchronous and active-low.
REQ-005 Port clk SHALL be: input, 1, system clock (25 MHz nominal), all logic on posedge.
REQ-006 Port rst_n SHALL be: input, 1, synchronous active-low reset.
REQ-007 Port en SHALL be: input, 1, access request strobe.
REQ-008 Port wr SHALL be: input, 1, 1 = write, 0 = read; valid with en.
REQ-009 Port addr SHALL be: input, ADDR_W, word address; valid with en.
REQ-010 Port wdata SHALL be: input, DATA_W, write data; valid with en & wr.
REQ-011 Port ready SHALL be: output, 1, block can accept a request this cycle.
REQ-012 Port rdata SHALL be: output, DATA_W, read data; valid while rvalid.
REQ-013 Port rvalid SHALL be: output, 1, one-cycle pulse qualifying rdata.
REQ-014 Port wr_cnt SHALL be: output, CNT_W, number of accepted writes.
REQ-015 Port rd_cnt SHALL be: output, CNT_W, number of accepted reads.
REQ-016 Port err SHALL be: output, 1, one-cycle pulse on a rejected access (REQ-031 only).

Function
REQ-017 The block SHALL hold a 2**ADDR_W x DATA_W register-array memory.
REQ-018 The FSM SHALL have exactly four states: IDLE, WRITE, READ, RESP.
REQ-019 A request SHALL be accepted only at a posedge where en=1 and ready=1; ready SHALL be 1 only in IDLE.
REQ-020 On acceptance the block SHALL capture addr, wr and wdata in the same edge.
REQ-021 Accept with wr=1: IDLE->WRITE; in WRITE, mem[addr]<=wdata; WRITE->IDLE next edge (2-cycle occupancy).
REQ-022 Accept with wr=0: IDLE->READ; READ reads mem[addr] into the rdata register; READ->RESP; RESP drives rvalid=1 for exactly one cycle; RESP->IDLE.
REQ-023 rvalid SHALL rise exactly 2 clocks after the accepting edge; rdata SHALL hold its last value when rvalid=0.
REQ-024 en while ready=0 SHALL be ignored, not queued, and SHALL NOT change the counters.
REQ-025 A read of an address written by the immediately preceding accepted write SHALL return the new data.
REQ-026 Addresses SHALL span 0..2**ADDR_W-1 with no wrap or alias; every address SHALL be valid.
REQ-027 wr_cnt/rd_cnt SHALL increment by 1 on each accepted write/read and saturate at all-ones.
REQ-028 X on wr/addr/wdata while en=0 SHALL have no effect.

Reset
REQ-029 With rst_n=0 at a posedge: FSM->IDLE; ready=1 from the next cycle; rvalid=0; err=0; rdata=0; wr_cnt=0; rd_cnt=0; all memory words=0.
REQ-030 Reset mid-operation (WRITE/READ/RESP) SHALL abort the access: no memory write completes and no rvalid pulse is produced.

Configuration
REQ-031 With MEM_WPROT_EN defined: accepted writes to addresses 0x38-0x3F SHALL NOT modify memory, SHALL still take the WRITE state, SHALL pulse err in the WRITE cycle, and SHALL NOT increment wr_cnt.
REQ-032 Without MEM_WPROT_EN: all addresses SHALL be writable and err SHALL be tied to 0.

Structure
REQ-033 Package mem_slave_pkg SHALL hold the FSM state enum, WPROT_BASE=6'h38 and WPROT_LAST=6'h3F.
REQ-034 Counters SHALL be instances of one sub-module sat_counter (parameter WIDTH; ports clk, rst_n, inc, count).

Verification
REQ-035 The bench SHALL check: write addr=0x05 wdata=0xA5, then read 0x05 -> rvalid 2 clocks after read accept, rdata=0xA5, wr_cnt=1, rd_cnt=1.
REQ-036 The bench SHALL check: en=1 held on the cycle after a write accept -> ready=0, request ignored, wr_cnt unchanged.
REQ-037 The bench SHALL check: write 0x3F=0x11, 0x00=0x22; read both -> 0x11, 0x22 (address extremes).
REQ-038 The bench SHALL check: rst_n=0 during READ -> no rvalid; after reset a read of 0x05 -> 0x00 and both counters=0.
REQ-039 The bench SHALL check: with MEM_WPROT_EN, write 0x3A=0xFF -> err pulse, read 0x3A -> 0x00, wr_cnt unchanged; without the macro -> read 0x3A returns 0xFF and err stays 0.
REQ-040 The bench SHALL check: force wr_cnt to 0xFFFE, issue 3 writes -> wr_cnt=0xFFFF.
